// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: sequential advance, redirects,
// a circular return-address stack and free-running cycle/stall counters.
module pc_unit #(
  parameter int unsigned             WIDTH        = 32,
  parameter int unsigned             INCR         = 1,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]        EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned             RAS_DEPTH    = 4,
  parameter int unsigned             CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 exc,
  input  logic                 stall,
  input  logic                 ret,
  input  logic                 call,
  input  logic                 bj,
  input  logic [WIDTH-1:0]     target,
  output logic [WIDTH-1:0]     pc,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_ovf,
  output logic                 ras_unf,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic [CNT_WIDTH-1:0] stalls
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0]        PTR_ONE = PW'(1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [CW-1:0]        CNT_MAX = CW'(RAS_DEPTH);
  localparam logic [CNT_WIDTH-1:0] PERF_ONE = CNT_WIDTH'(1);
  localparam logic [WIDTH-1:0]     PC_INCR = WIDTH'(INCR);

  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_ras [RAS_DEPTH];
  logic [PW-1:0]        r_wp;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic                 r_unf;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic [CNT_WIDTH-1:0] r_stalls;

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;
  logic             w_empty;
  logic             w_full;
  logic             w_active;
  logic             w_push;

  assign w_pc_inc = r_pc + PC_INCR;
  assign w_top    = r_ras[r_wp - PTR_ONE];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_MAX);
  // Redirect inputs only matter when nothing of higher priority is asserted.
  assign w_active = !rst && !halt && !exc && !stall;
  assign w_push   = w_active && !ret && call;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_VECTOR;
      r_wp     <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_cycles <= '0;
      r_stalls <= '0;
    end else if (!halt) begin
      r_cycles <= r_cycles + PERF_ONE;
      if (exc) begin
        r_pc  <= EXC_VECTOR;
        r_cnt <= '0;
      end else if (stall) begin
        r_stalls <= r_stalls + PERF_ONE;
      end else if (ret) begin
        if (!w_empty) begin
          r_pc  <= w_top;
          r_cnt <= r_cnt - CNT_ONE;
          r_wp  <= r_wp - PTR_ONE;
        end else begin
          r_pc  <= w_pc_inc;
          r_unf <= 1'b1;
        end
      end else if (call) begin
        r_pc <= target;
        r_wp <= r_wp + PTR_ONE;
        // A full stack overwrites its oldest entry and keeps the count pinned.
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CNT_ONE;
      end else if (bj) begin
        r_pc <= target;
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_wp] <= w_pc_inc;
  end

  assign pc        = r_pc;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;
  assign cycles    = r_cycles;
  assign stalls    = r_stalls;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: driver pushes hand-computed expectations per edge,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_unit;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b1000000;
  localparam logic [6:0] C_HALT  = 7'b0100000;
  localparam logic [6:0] C_EXC   = 7'b0010000;
  localparam logic [6:0] C_STALL = 7'b0001000;
  localparam logic [6:0] C_RET   = 7'b0000100;
  localparam logic [6:0] C_CALL  = 7'b0000010;
  localparam logic [6:0] C_BJ    = 7'b0000001;

  // flags = {empty, full, ovf, unf}
  localparam logic [3:0] F_E  = 4'b1000;
  localparam logic [3:0] F_0  = 4'b0000;

  localparam int EW = 32 + 4 + 32 + 32;

  logic        clk;
  logic        rst, halt, exc, stall, ret, call, bj;
  logic [31:0] target;
  logic [31:0] pc;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
  logic [31:0] cycles, stalls;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_cyc;
  logic [31:0]   exp_stl;
  int            n_cmp;
  int            n_fail;
  int            n_obs;

  pc_unit dut (
    .clk(clk), .rst(rst), .halt(halt), .exc(exc), .stall(stall),
    .ret(ret), .call(call), .bj(bj), .target(target),
    .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .cycles(cycles), .stalls(stalls)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: apply one cycle of controls at negedge, expectation pushed after the edge
  task automatic step(input logic [6:0] ctl, input logic [31:0] tgt,
                      input logic [31:0] epc, input logic [3:0] eflags);
    {rst, halt, exc, stall, ret, call, bj} = ctl;
    target = tgt;
    if (ctl[6]) begin
      exp_cyc = 0;
      exp_stl = 0;
    end else if (!ctl[5]) begin
      exp_cyc = exp_cyc + 1;
      if (ctl[3] && !ctl[4]) exp_stl = exp_stl + 1;
    end
    @(posedge clk);
    exp_q.push_back({epc, eflags, exp_cyc, exp_stl});
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s obs%0d: got %h want %h", name, n_obs, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("pc",     pc,                                       e[99:68]);
      check("flags",  {28'd0, ras_empty, ras_full, ras_ovf, ras_unf}, {28'd0, e[67:64]});
      check("cycles", cycles,                                   e[63:32]);
      check("stalls", stalls,                                   e[31:0]);
      n_obs++;
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; n_obs = 0;
    exp_cyc = 0; exp_stl = 0;
    {rst, halt, exc, stall, ret, call, bj} = C_RST;
    target = '0;
    @(negedge clk);

    // reset and free-run
    step(C_RST, 0, 32'd0, F_E);
    for (int i = 1; i <= 7; i++) step(C_NONE, 0, 32'(i), F_E);

    // call then immediate ret
    step(C_CALL, 32'h100, 32'h100, F_0);
    step(C_RET,  0,       32'd8,   F_E);
    step(C_NONE, 0, 32'd9,  F_E);
    step(C_NONE, 0, 32'd10, F_E);

    // stalls hold pc; call under stall is ignored
    step(C_STALL,          0,      32'd10, F_E);
    step(C_STALL,          0,      32'd10, F_E);
    step(C_STALL | C_CALL, 32'h77, 32'd10, F_E);
    step(C_BJ,             32'h40, 32'h40, F_E);

    // five calls overflow a 4-deep RAS, five rets drain and underflow
    step(C_BJ,   32'd1, 32'd1, F_E);
    step(C_CALL, 32'd2, 32'd2, F_0);
    step(C_CALL, 32'd3, 32'd3, F_0);
    step(C_CALL, 32'd4, 32'd4, F_0);
    step(C_CALL, 32'd5, 32'd5, 4'b0100);
    step(C_CALL, 32'd6, 32'd6, 4'b0110);
    step(C_RET,  0, 32'd6, 4'b0010);
    step(C_RET,  0, 32'd5, 4'b0010);
    step(C_RET,  0, 32'd4, 4'b0010);
    step(C_RET,  0, 32'd3, 4'b1010);
    step(C_RET,  0, 32'd4, 4'b1011);

    // exception beats stall and bj, flushes RAS, keeps sticky flags
    step(C_CALL, 32'h10, 32'h10, 4'b0011);
    step(C_CALL, 32'h2F, 32'h2F, 4'b0011);
    step(C_NONE, 0,      32'h30, 4'b0011);
    step(C_EXC | C_STALL | C_BJ, 32'h99, 32'h20, 4'b1011);

    // ret beats call; call beats bj
    step(C_CALL,         32'h50, 32'h50, 4'b0011);
    step(C_RET | C_CALL, 32'h77, 32'h21, 4'b1011);
    step(C_CALL | C_BJ,  32'h60, 32'h60, 4'b0011);
    step(C_RET,          0,      32'h22, 4'b1011);

    // halt freezes everything; rst still wins over halt
    step(C_HALT,         0,      32'h22, 4'b1011);
    step(C_HALT | C_EXC, 0,      32'h22, 4'b1011);
    step(C_RST | C_HALT, 0,      32'd0,  F_E);
    step(C_HALT | C_BJ,  32'h5,  32'd0,  F_E);
    step(C_NONE,         0,      32'd1,  F_E);

    // pc wraps modulo 2^32
    step(C_BJ,   32'hFFFF_FFFF, 32'hFFFF_FFFF, F_E);
    step(C_NONE, 0,             32'd0,         F_E);

    {rst, halt, exc, stall, ret, call, bj} = C_NONE;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
